ptp_pulse_monitor: RTL and testbench
====================================

PTP_PULSE_MONITOR -- requirements
Module: ptp_pulse_monitor

Interface
REQ-001 SHALL have parameter TIME_WIDTH, default 30; time/count fields are TIME_WIDTH+1 bits wide.
REQ-002 SHALL have parameter CNT_WIDTH, default 11; width of the pulse counter.
REQ-003 SHALL have port clk, input, 1, the single clock for all state.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pulse_in, input, 1, registered periodic pulse from the upstream period-out stage.
REQ-006 SHALL have port error_in, input, 1, error strobe from the upstream stage.
REQ-007 SHALL have port cfg_valid, input, 1, one-cycle strobe that loads the expected configuration.
REQ-008 SHALL have ports cfg_period and cfg_width, input, TIME_WIDTH+1 each, expected period and high width in cycles.
REQ-009 SHALL have port cfg_tol, input, 8, allowed deviation in cycles.
REQ-010 SHALL have port meas_valid, output, 1, one-cycle strobe marking a new measurement.
REQ-011 SHALL have ports meas_period and meas_width, output, TIME_WIDTH+1 each, last measured period and width.
REQ-012 SHALL have port pulse_count, output, CNT_WIDTH, rising edges seen since arm.
REQ-013 SHALL have ports period_err, width_err, timeout_err and upstream_err, output, 1 each, sticky error flags.

Function
REQ-014 SHALL keep pulse_q, the previous-cycle pulse_in; rise = pulse_in & ~pulse_q; fall = ~pulse_in & pulse_q.
REQ-015 SHALL implement states IDLE, ARMED, HIGH, LOW.
REQ-016 IDLE SHALL move to ARMED on cfg_valid, latching cfg_period, cfg_width and cfg_tol, and clearing pulse_count and all error flags.
REQ-017 ARMED SHALL move to HIGH on rise, set per_cnt=1 and hi_cnt=1, and increment pulse_count.
REQ-018 HIGH SHALL increment per_cnt and hi_cnt each cycle; on fall it SHALL set meas_width=hi_cnt and move to LOW.
REQ-019 LOW SHALL increment per_cnt each cycle; on rise it SHALL set meas_period=per_cnt and per_cnt=1, hi_cnt=1, increment pulse_count and move to HIGH.
REQ-020 The cycle after a rise in LOW, meas_valid SHALL pulse high for exactly one cycle; no other event drives meas_valid.
REQ-021 width_err SHALL set on fall when |hi_cnt - cfg_width| > cfg_tol; period_err SHALL set on a LOW-state rise when |per_cnt - cfg_period| > cfg_tol.
REQ-022 All counters SHALL saturate at all-ones and never wrap; pulse_count SHALL saturate at 2^CNT_WIDTH-1.
REQ-023 error_in=1 SHALL set upstream_err and force IDLE; measurement registers SHALL hold their values.
REQ-024 cfg_valid in any non-IDLE state SHALL re-arm, with behaviour identical to REQ-016, and SHALL take priority over a simultaneous rise or fall.
REQ-025 error_in SHALL take priority over cfg_valid in the same cycle.
REQ-026 Error flags SHALL be sticky until re-arm or reset.

Reset
REQ-027 On rst_n low, regardless of clk: state=IDLE, pulse_q=0, all counters=0, meas_period=0, meas_width=0, pulse_count=0, meas_valid=0, all error flags=0.
REQ-028 Reset mid-measurement SHALL discard the partial counts; no meas_valid SHALL occur until re-armed and two rises have been seen.

Configuration
REQ-029 Macro PTP_PULSE_MON_TIMEOUT_EN defined: in HIGH or LOW, when per_cnt > cfg_period + cfg_tol, timeout_err SHALL set and the state SHALL move to ARMED.
REQ-030 Macro PTP_PULSE_MON_TIMEOUT_EN undefined: timeout_err SHALL be tied to 0 and no timeout logic SHALL exist.

Structure
REQ-031 Package ptp_pkg SHALL hold the TIME_WIDTH default, the monitor state enum and the tolerance width constant.
REQ-032 Edge detection SHALL be the sub-module ptp_edge_detect, which outputs rise and fall; all else is inline.

Verification
REQ-033 Arm with period=60, width=20, tol=0, then drive 5 exact pulses -> meas_period=60, meas_width=20, pulse_count=5, 4 meas_valid strobes, no errors.
REQ-034 Arm with width=20, tol=2, then drive a 25-cycle high -> width_err=1 at the fall; drive a 22-cycle high -> width_err is not set.
REQ-035 With the macro defined, arm with period=60, tol=2, give one rise, then hold low -> timeout_err=1 when per_cnt reaches 63, state=ARMED; with the macro undefined -> timeout_err stays 0.
REQ-036 Assert rst_n low during the HIGH state -> all outputs 0 asynchronously; after re-arm, the first meas_valid follows the second rise.
REQ-037 Drive cfg_valid together with a rise -> re-arm occurs and pulse_count=0; drive error_in together with cfg_valid -> IDLE and upstream_err=1.
REQ-038 Drive 2^CNT_WIDTH+3 pulses -> pulse_count holds at 2047.

Source files
------------

// File: rtl/ptp_pkg.sv
// rtl/ptp_pkg.sv - shared constants and state encoding for the PTP pulse monitor
package ptp_pkg;

    localparam int PTP_TIME_WIDTH = 30;
    localparam int PTP_TOL_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } ptp_state_e;

endpackage

// File: rtl/ptp_edge_detect.sv
// rtl/ptp_edge_detect.sv - rise/fall detector on the registered upstream pulse
module ptp_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic rise,
    output logic fall
);

    logic pulse_q;
    logic pulse_d;

    always_comb pulse_d = pulse_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign rise = pulse_in & ~pulse_q;
    assign fall = ~pulse_in & pulse_q;

endmodule

// File: rtl/ptp_pulse_monitor.sv
// rtl/ptp_pulse_monitor.sv - period/width checker for the PTP periodic pulse
// Optional stall detection is built when PTP_PULSE_MON_TIMEOUT_EN is defined.
module ptp_pulse_monitor
    import ptp_pkg::*;
#(
    parameter int TIME_WIDTH = PTP_TIME_WIDTH,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pulse_in,
    input  logic                     error_in,
    input  logic                     cfg_valid,
    input  logic [TIME_WIDTH:0]      cfg_period,
    input  logic [TIME_WIDTH:0]      cfg_width,
    input  logic [PTP_TOL_WIDTH-1:0] cfg_tol,
    output logic                     meas_valid,
    output logic [TIME_WIDTH:0]      meas_period,
    output logic [TIME_WIDTH:0]      meas_width,
    output logic [CNT_WIDTH-1:0]     pulse_count,
    output logic                     period_err,
    output logic                     width_err,
    output logic                     timeout_err,
    output logic                     upstream_err
);

    localparam int TW  = TIME_WIDTH + 1;
    localparam int TWX = TW + 1;
    typedef logic [TW-1:0] time_t;

    function automatic time_t sat_inc(input time_t v);
        return (&v) ? v : v + time_t'(1);
    endfunction

    function automatic logic out_of_tol(input time_t a, input time_t b,
                                        input logic [PTP_TOL_WIDTH-1:0] tol);
        time_t diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return diff > time_t'(tol);
    endfunction

    logic rise;
    logic fall;

    ptp_edge_detect u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .rise     (rise),
        .fall     (fall)
    );

    ptp_state_e               state_q, state_d;
    time_t                    per_cnt_q, per_cnt_d;
    time_t                    hi_cnt_q, hi_cnt_d;
    time_t                    cfg_period_q, cfg_period_d;
    time_t                    cfg_width_q, cfg_width_d;
    logic [PTP_TOL_WIDTH-1:0] cfg_tol_q, cfg_tol_d;
    time_t                    meas_period_q, meas_period_d;
    time_t                    meas_width_q, meas_width_d;
    logic [CNT_WIDTH-1:0]     pulse_count_q, pulse_count_d;
    logic                     meas_valid_q, meas_valid_d;
    logic                     period_err_q, period_err_d;
    logic                     width_err_q, width_err_d;
    logic                     upstream_err_q, upstream_err_d;

`ifdef PTP_PULSE_MON_TIMEOUT_EN
    logic           timeout_err_q, timeout_err_d;
    logic           timeout_hit;
    logic [TWX-1:0] timeout_limit;

    // Extra bit keeps period + tolerance from wrapping near full scale.
    assign timeout_limit = {1'b0, cfg_period_q} + TWX'(cfg_tol_q);
    assign timeout_hit   = ((state_q == ST_HIGH) || (state_q == ST_LOW)) &&
                           ({1'b0, per_cnt_q} > timeout_limit);
    assign timeout_err   = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        per_cnt_d      = per_cnt_q;
        hi_cnt_d       = hi_cnt_q;
        cfg_period_d   = cfg_period_q;
        cfg_width_d    = cfg_width_q;
        cfg_tol_d      = cfg_tol_q;
        meas_period_d  = meas_period_q;
        meas_width_d   = meas_width_q;
        pulse_count_d  = pulse_count_q;
        meas_valid_d   = 1'b0;
        period_err_d   = period_err_q;
        width_err_d    = width_err_q;
        upstream_err_d = upstream_err_q;
`ifdef PTP_PULSE_MON_TIMEOUT_EN
        timeout_err_d  = timeout_err_q;
`endif
        if (error_in) begin
            upstream_err_d = 1'b1;
            state_d        = ST_IDLE;
        end else if (cfg_valid) begin
            state_d        = ST_ARMED;
            cfg_period_d   = cfg_period;
            cfg_width_d    = cfg_width;
            cfg_tol_d      = cfg_tol;
            per_cnt_d      = '0;
            hi_cnt_d       = '0;
            pulse_count_d  = '0;
            period_err_d   = 1'b0;
            width_err_d    = 1'b0;
            upstream_err_d = 1'b0;
`ifdef PTP_PULSE_MON_TIMEOUT_EN
            timeout_err_d  = 1'b0;
        end else if (timeout_hit) begin
            timeout_err_d  = 1'b1;
            state_d        = ST_ARMED;
`endif
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (rise) begin
                        state_d       = ST_HIGH;
                        per_cnt_d     = time_t'(1);
                        hi_cnt_d      = time_t'(1);
                        pulse_count_d = (&pulse_count_q) ? pulse_count_q
                                                         : pulse_count_q + CNT_WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    per_cnt_d = sat_inc(per_cnt_q);
                    hi_cnt_d  = sat_inc(hi_cnt_q);
                    if (fall) begin
                        meas_width_d = hi_cnt_q;
                        state_d      = ST_LOW;
                        if (out_of_tol(hi_cnt_q, cfg_width_q, cfg_tol_q)) begin
                            width_err_d = 1'b1;
                        end
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        meas_period_d = per_cnt_q;
                        per_cnt_d     = time_t'(1);
                        hi_cnt_d      = time_t'(1);
                        pulse_count_d = (&pulse_count_q) ? pulse_count_q
                                                         : pulse_count_q + CNT_WIDTH'(1);
                        meas_valid_d  = 1'b1;
                        state_d       = ST_HIGH;
                        if (out_of_tol(per_cnt_q, cfg_period_q, cfg_tol_q)) begin
                            period_err_d = 1'b1;
                        end
                    end else begin
                        per_cnt_d = sat_inc(per_cnt_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            per_cnt_q      <= '0;
            hi_cnt_q       <= '0;
            cfg_period_q   <= '0;
            cfg_width_q    <= '0;
            cfg_tol_q      <= '0;
            meas_period_q  <= '0;
            meas_width_q   <= '0;
            pulse_count_q  <= '0;
            meas_valid_q   <= 1'b0;
            period_err_q   <= 1'b0;
            width_err_q    <= 1'b0;
            upstream_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            per_cnt_q      <= per_cnt_d;
            hi_cnt_q       <= hi_cnt_d;
            cfg_period_q   <= cfg_period_d;
            cfg_width_q    <= cfg_width_d;
            cfg_tol_q      <= cfg_tol_d;
            meas_period_q  <= meas_period_d;
            meas_width_q   <= meas_width_d;
            pulse_count_q  <= pulse_count_d;
            meas_valid_q   <= meas_valid_d;
            period_err_q   <= period_err_d;
            width_err_q    <= width_err_d;
            upstream_err_q <= upstream_err_d;
        end
    end

`ifdef PTP_PULSE_MON_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end
`endif

    assign meas_valid   = meas_valid_q;
    assign meas_period  = meas_period_q;
    assign meas_width   = meas_width_q;
    assign pulse_count  = pulse_count_q;
    assign period_err   = period_err_q;
    assign width_err    = width_err_q;
    assign upstream_err = upstream_err_q;

endmodule

// File: tb/tb_ptp_pulse_monitor.sv
// tb/tb_ptp_pulse_monitor.sv - directed scoreboard bench for ptp_pulse_monitor
`timescale 1ns/1ps
module tb_ptp_pulse_monitor;
    import ptp_pkg::*;

    localparam int TIME_WIDTH = 30;
    localparam int CNT_WIDTH  = 11;

    logic                  clk;
    logic                  rst_n;
    logic                  pulse_in;
    logic                  error_in;
    logic                  cfg_valid;
    logic [TIME_WIDTH:0]   cfg_period;
    logic [TIME_WIDTH:0]   cfg_width;
    logic [7:0]            cfg_tol;
    logic                  meas_valid;
    logic [TIME_WIDTH:0]   meas_period;
    logic [TIME_WIDTH:0]   meas_width;
    logic [CNT_WIDTH-1:0]  pulse_count;
    logic                  period_err;
    logic                  width_err;
    logic                  timeout_err;
    logic                  upstream_err;

    ptp_pulse_monitor #(
        .TIME_WIDTH (TIME_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .error_in     (error_in),
        .cfg_valid    (cfg_valid),
        .cfg_period   (cfg_period),
        .cfg_width    (cfg_width),
        .cfg_tol      (cfg_tol),
        .meas_valid   (meas_valid),
        .meas_period  (meas_period),
        .meas_width   (meas_width),
        .pulse_count  (pulse_count),
        .period_err   (period_err),
        .width_err    (width_err),
        .timeout_err  (timeout_err),
        .upstream_err (upstream_err)
    );

    typedef struct {
        int per;
        int wid;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   strobes     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && meas_valid) begin
            exp_t e;
            strobes++;
            vectors++;
            assert (sb_q.size() != 0) else begin
                miscompares++;
                $error("FAIL meas_valid_unexpected: observed strobe expected none, period %0d width %0d",
                       meas_period, meas_width);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("meas_period", 64'(meas_period), 64'(e.per));
                check("meas_width", 64'(meas_width), 64'(e.wid));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int per, input int wid, input int tol);
        cfg_period = (TIME_WIDTH+1)'(per);
        cfg_width  = (TIME_WIDTH+1)'(wid);
        cfg_tol    = 8'(tol);
        cfg_valid  = 1'b1;
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic drive_pulse(input int hi, input int lo, input bit expect_meas,
                               input int exp_per, input int exp_wid);
        exp_t e;
        if (expect_meas) begin
            e.per = exp_per;
            e.wid = exp_wid;
            sb_q.push_back(e);
        end
        pulse_in = 1'b1;
        repeat (hi) step();
        pulse_in = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        int s0;
        int first_cyc;

        rst_n      = 1'b0;
        pulse_in   = 1'b0;
        error_in   = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_width  = '0;
        cfg_tol    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_meas_period", 64'(meas_period), 0);
        check("rst_meas_width", 64'(meas_width), 0);
        check("rst_pulse_count", 64'(pulse_count), 0);
        check("rst_meas_valid", 64'(meas_valid), 0);
        check("rst_errors", 64'({period_err, width_err, timeout_err, upstream_err}), 0);
        rst_n = 1'b1;
        step();

        // exact pulses
        arm(60, 20, 0);
        s0 = strobes;
        for (int i = 0; i < 5; i++) drive_pulse(20, 40, i > 0, 60, 20);
        check("exact_pulse_count", 64'(pulse_count), 5);
        check("exact_strobes", 64'(strobes - s0), 4);
        check("exact_meas_period", 64'(meas_period), 60);
        check("exact_meas_width", 64'(meas_width), 20);
        check("exact_errors", 64'({period_err, width_err, timeout_err, upstream_err}), 0);

        // width tolerance
        arm(60, 20, 2);
        drive_pulse(25, 35, 0, 0, 0);
        check("wide_width_err", 64'(width_err), 1);
        check("wide_meas_width", 64'(meas_width), 25);
        arm(60, 20, 2);
        drive_pulse(22, 38, 0, 0, 0);
        check("edge_width_err", 64'(width_err), 0);
        check("edge_meas_width", 64'(meas_width), 22);
        drive_pulse(20, 35, 1, 60, 22);
        check("period_ok_err", 64'(period_err), 0);
        drive_pulse(20, 20, 1, 55, 20);
        check("period_bad_err", 64'(period_err), 1);
        check("period_bad_width_err", 64'(width_err), 0);

        // stall after one rise
        arm(60, 20, 2);
        pulse_in = 1'b1;
        step();
        first_cyc = 0;
        for (int c = 1; c <= 150; c++) begin
            if (c == 20) pulse_in = 1'b0;
            step();
            if (first_cyc == 0 && timeout_err) first_cyc = c;
        end
`ifdef PTP_PULSE_MON_TIMEOUT_EN
        check("timeout_cycle", 64'(first_cyc), 63);
        check("timeout_err", 64'(timeout_err), 1);
        check("timeout_state", 64'(dut.state_q), 64'(ST_ARMED));
`else
        check("timeout_never", 64'(first_cyc), 0);
        check("timeout_err_tied", 64'(timeout_err), 0);
`endif

        // async reset mid-high
        arm(60, 20, 0);
        pulse_in = 1'b1;
        repeat (10) step();
        check("pre_rst_pulse_count", 64'(pulse_count), 1);
        rst_n = 1'b0;
        #1;
        check("async_meas_period", 64'(meas_period), 0);
        check("async_meas_width", 64'(meas_width), 0);
        check("async_pulse_count", 64'(pulse_count), 0);
        check("async_flags", 64'({meas_valid, period_err, width_err, timeout_err, upstream_err}), 0);
        step();
        rst_n    = 1'b1;
        pulse_in = 1'b0;
        step();
        arm(60, 20, 0);
        s0 = strobes;
        drive_pulse(20, 40, 0, 0, 0);
        check("post_rst_first_rise_strobes", 64'(strobes - s0), 0);
        drive_pulse(20, 40, 1, 60, 20);
        check("post_rst_second_rise_strobes", 64'(strobes - s0), 1);

        // cfg_valid beats rise, error_in beats cfg_valid
        arm(60, 20, 0);
        drive_pulse(20, 10, 0, 0, 0);
        check("pre_rearm_count", 64'(pulse_count), 1);
        pulse_in  = 1'b1;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("rearm_count", 64'(pulse_count), 0);
        check("rearm_state", 64'(dut.state_q), 64'(ST_ARMED));
        step();
        check("rearm_no_rise_count", 64'(pulse_count), 0);
        pulse_in = 1'b0;
        repeat (2) step();
        error_in  = 1'b1;
        cfg_valid = 1'b1;
        step();
        error_in  = 1'b0;
        cfg_valid = 1'b0;
        check("err_state", 64'(dut.state_q), 64'(ST_IDLE));
        check("err_upstream", 64'(upstream_err), 1);
        check("err_meas_width_hold", 64'(meas_width), 20);

        // pulse counter saturation
        arm(2, 1, 0);
        for (int i = 0; i < (1 << CNT_WIDTH) + 3; i++) drive_pulse(1, 1, i > 0, 2, 1);
        check("sat_pulse_count", 64'(pulse_count), 2047);
        check("sat_errors", 64'({period_err, width_err, timeout_err}), 0);

        repeat (3) step();
        check("scoreboard_drained", 64'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
